uart_host_sequencer: RTL and testbench

- Host-side initiator for the sensor board's single-byte UART command protocol.
- Issues the commands ENQ 0x05, ACQ 0x01, ST 0x02 and RST 0x20, plus an arbitrary echo byte, to the sensor controller. It then checks the response: ACK 0x06 or the echoed byte.
- For ST it reassembles the returned 16-bit sample stream, MSB byte first, into words.
- Sits between a byte-level UART core and a bench or host-side buffer; used for board-to-board links and loopback test rigs.

---
 rtl/uart_host_sequencer_if.sv | 31 +++
 rtl/uart_host_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_uart_host_sequencer.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_host_sequencer_if.sv
// Bundles the command, UART byte and result signals of the host sequencer.
// The sequencer takes the slave modport; the host or bench takes master.
interface uart_host_sequencer_if;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic [2:0]  cmd_op_i;
    logic [7:0]  cmd_arg_i;
    logic [7:0]  tx_byte_o;
    logic        tx_valid_o;
    logic        tx_ready_i;
    logic [7:0]  rx_byte_i;
    logic        rx_valid_i;
    logic [15:0] word_data_o;
    logic        word_valid_o;
    logic [10:0] word_count_o;
    logic        done_o;
    logic [1:0]  status_o;
    logic        busy_o;

    modport slave (
        input  cmd_valid_i, cmd_op_i, cmd_arg_i, tx_ready_i, rx_byte_i, rx_valid_i,
        output cmd_ready_o, tx_byte_o, tx_valid_o, word_data_o, word_valid_o,
               word_count_o, done_o, status_o, busy_o
    );

    modport master (
        output cmd_valid_i, cmd_op_i, cmd_arg_i, tx_ready_i, rx_byte_i, rx_valid_i,
        input  cmd_ready_o, tx_byte_o, tx_valid_o, word_data_o, word_valid_o,
               word_count_o, done_o, status_o, busy_o
    );
endinterface

// File: rtl/uart_host_sequencer.sv
// Host-side initiator for the single-byte UART command protocol: sends one
// command byte, checks the ACK/echo reply, or reassembles ST sample words.
module uart_host_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 5000000,
    parameter int unsigned MAX_WORDS      = 1024,
    parameter int unsigned CNT_W          = 24
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    uart_host_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_ACK,
        RX_HI,
        RX_LO,
        FINISH
    } state_t;

    localparam logic [2:0] OP_ENQ  = 3'd0;
    localparam logic [2:0] OP_ACQ  = 3'd1;
    localparam logic [2:0] OP_ST   = 3'd2;
    localparam logic [2:0] OP_RST  = 3'd3;
    localparam logic [2:0] OP_ECHO = 3'd4;

    localparam logic [1:0] ST_OK      = 2'd0;
    localparam logic [1:0] ST_BAD     = 2'd1;
    localparam logic [1:0] ST_TIMEOUT = 2'd2;
    localparam logic [1:0] ST_SHORT   = 2'd3;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [10:0]      MAX_CNT  = 11'(MAX_WORDS);

    state_t            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [7:0]        arg_q, arg_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        hi_q, hi_d;

    logic              cmd_ready_q, cmd_ready_d;
    logic [7:0]        tx_byte_q, tx_byte_d;
    logic              tx_valid_q, tx_valid_d;
    logic [15:0]       word_data_q, word_data_d;
    logic              word_valid_q, word_valid_d;
    logic [10:0]       word_count_q, word_count_d;
    logic              done_q, done_d;
    logic [1:0]        status_q, status_d;
    logic              busy_q, busy_d;

    logic              timeoutHit;
    logic              waiting;
    logic [7:0]        expectedByte;

    assign timeoutHit   = (cnt_q == CNT_LAST);
    assign waiting      = (state_q == WAIT_ACK) || (state_q == RX_HI) || (state_q == RX_LO);
    assign expectedByte = (op_q == OP_ECHO) ? arg_q : 8'h06;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            op_q         <= '0;
            arg_q        <= '0;
            cnt_q        <= '0;
            hi_q         <= '0;
            cmd_ready_q  <= 1'b1;
            tx_byte_q    <= '0;
            tx_valid_q   <= 1'b0;
            word_data_q  <= '0;
            word_valid_q <= 1'b0;
            word_count_q <= '0;
            done_q       <= 1'b0;
            status_q     <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            arg_q        <= arg_d;
            cnt_q        <= cnt_d;
            hi_q         <= hi_d;
            cmd_ready_q  <= cmd_ready_d;
            tx_byte_q    <= tx_byte_d;
            tx_valid_q   <= tx_valid_d;
            word_data_q  <= word_data_d;
            word_valid_q <= word_valid_d;
            word_count_q <= word_count_d;
            done_q       <= done_d;
            status_q     <= status_d;
            busy_q       <= busy_d;
        end
    end

    // A received byte always takes priority over the timeout firing in the same cycle.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        arg_d        = arg_q;
        cnt_d        = cnt_q;
        hi_d         = hi_q;
        tx_byte_d    = tx_byte_q;
        word_data_d  = word_data_q;
        word_valid_d = 1'b0;
        word_count_d = word_count_q;
        status_d     = status_q;

        if (waiting && !timeoutHit && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (bus.cmd_valid_i) begin
                    op_d         = bus.cmd_op_i;
                    arg_d        = bus.cmd_arg_i;
                    word_count_d = '0;
                    status_d     = ST_OK;
                    case (bus.cmd_op_i)
                        OP_ENQ:  tx_byte_d = 8'h05;
                        OP_ACQ:  tx_byte_d = 8'h01;
                        OP_ST:   tx_byte_d = 8'h02;
                        OP_RST:  tx_byte_d = 8'h20;
                        default: tx_byte_d = bus.cmd_arg_i;
                    endcase
                    if (bus.cmd_op_i > OP_ECHO) begin
                        state_d  = FINISH;
                        status_d = ST_BAD;
                    end else begin
                        state_d = SEND;
                    end
                end
            end
            SEND: begin
                if (bus.tx_ready_i) begin
                    cnt_d = '0;
                    case (op_q)
                        OP_RST:  state_d = FINISH;
                        OP_ST:   state_d = RX_HI;
                        default: state_d = WAIT_ACK;
                    endcase
                end
            end
            WAIT_ACK: begin
                if (bus.rx_valid_i) begin
                    state_d  = FINISH;
                    status_d = (bus.rx_byte_i == expectedByte) ? ST_OK : ST_BAD;
                end else if (timeoutHit) begin
                    state_d  = FINISH;
                    status_d = ST_TIMEOUT;
                end
            end
            RX_HI: begin
                if (bus.rx_valid_i) begin
                    hi_d    = bus.rx_byte_i;
                    cnt_d   = '0;
                    state_d = RX_LO;
                end else if (timeoutHit) begin
                    state_d  = FINISH;
                    status_d = (word_count_q == '0) ? ST_TIMEOUT : ST_SHORT;
                end
            end
            RX_LO: begin
                if (bus.rx_valid_i) begin
                    cnt_d        = '0;
                    word_data_d  = {hi_q, bus.rx_byte_i};
                    word_valid_d = 1'b1;
                    if (word_count_q != MAX_CNT) begin
                        word_count_d = word_count_q + 11'd1;
                    end
                    if ((word_count_q + 11'd1) == MAX_CNT) begin
                        state_d  = FINISH;
                        status_d = ST_OK;
                    end else begin
                        state_d = RX_HI;
                    end
                end else if (timeoutHit) begin
                    state_d  = FINISH;
                    status_d = ST_TIMEOUT;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake and strobe outputs follow the upcoming state so they stay registered.
    always_comb begin
        cmd_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
        tx_valid_d  = (state_d == SEND);
        done_d      = (state_d == FINISH);
    end

    assign bus.cmd_ready_o  = cmd_ready_q;
    assign bus.tx_byte_o    = tx_byte_q;
    assign bus.tx_valid_o   = tx_valid_q;
    assign bus.word_data_o  = word_data_q;
    assign bus.word_valid_o = word_valid_q;
    assign bus.word_count_o = word_count_q;
    assign bus.done_o       = done_q;
    assign bus.status_o     = status_q;
    assign bus.busy_o       = busy_q;

endmodule

// File: tb/tb_uart_host_sequencer.sv
// Self-checking bench for uart_host_sequencer: directed protocol scenarios
// plus randomized commands checked against a byte-stream reference model.
module tb_uart_host_sequencer;

    localparam int TIMEOUT = 100;
    localparam int MAXW    = 4;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    uart_host_sequencer_if bus();

    uart_host_sequencer #(
        .TIMEOUT_CYCLES(TIMEOUT),
        .MAX_WORDS     (MAXW),
        .CNT_W         (24)
    ) dut (
        .clk_i  (clk),
        .reset_i(reset),
        .bus    (bus.slave)
    );

    int          compareCount  = 0;
    int          mismatchCount = 0;
    int          doneCount     = 0;
    logic [15:0] wordQ[$];
    logic [7:0]  rxBytes[$];
    logic [15:0] expWords[$];
    int          expCount;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.word_valid_o) wordQ.push_back(bus.word_data_o);
            if (bus.done_o) doneCount++;
        end
    end

    // Reference model: outcome of a command given the full reply byte stream.
    function automatic int modelStatus(input logic [2:0] op, input logic [7:0] arg);
        int n;
        int pairs;
        int st;
        n = rxBytes.size();
        expWords.delete();
        expCount = 0;
        case (op)
            3'd0, 3'd1: st = (n == 0) ? 2 : ((rxBytes[0] == 8'h06) ? 0 : 1);
            3'd4:       st = (n == 0) ? 2 : ((rxBytes[0] == arg) ? 0 : 1);
            3'd3:       st = 0;
            3'd2: begin
                pairs = n / 2;
                if (pairs >= MAXW) begin
                    pairs = MAXW;
                    st = 0;
                end else if ((n % 2) == 1) st = 2;
                else if (pairs == 0)       st = 2;
                else                       st = 3;
                for (int i = 0; i < pairs; i++) expWords.push_back({rxBytes[2*i], rxBytes[2*i+1]});
                expCount = pairs;
            end
            default: st = 1;
        endcase
        return st;
    endfunction

    task automatic applyStimulus(input logic [2:0] op, input logic [7:0] arg, input int txDelay);
        int         doneBase;
        int         wordBase;
        int         cyc;
        int         expStatus;
        bit         sends;
        bit         timed;
        logic [7:0] expTx;

        sends = (op <= 3'd4);
        timed = sends && (op != 3'd3) && (rxBytes.size() == 0);
        case (op)
            3'd0:    expTx = 8'h05;
            3'd1:    expTx = 8'h01;
            3'd2:    expTx = 8'h02;
            3'd3:    expTx = 8'h20;
            default: expTx = arg;
        endcase
        expStatus = modelStatus(op, arg);
        doneBase  = doneCount;
        wordBase  = wordQ.size();

        checkOutput("cmd_ready idle", bus.cmd_ready_o, 1);
        bus.cmd_valid_i = 1'b1;
        bus.cmd_op_i    = op;
        bus.cmd_arg_i   = arg;
        @(negedge clk);
        bus.cmd_valid_i = 1'b0;
        bus.cmd_op_i    = 3'($urandom);
        bus.cmd_arg_i   = ~arg;
        checkOutput("busy after accept", bus.busy_o, 1);
        checkOutput("cmd_ready after accept", bus.cmd_ready_o, 0);
        checkOutput("tx_valid at t+1", bus.tx_valid_o, sends);
        checkOutput("status cleared on accept", bus.status_o, sends ? 0 : 1);
        checkOutput("word_count cleared", bus.word_count_o, 0);

        if (sends) begin
            checkOutput("tx_byte", bus.tx_byte_o, expTx);
            repeat (txDelay) begin
                @(negedge clk);
                checkOutput("tx held", {bus.tx_valid_o, bus.tx_byte_o}, {1'b1, expTx});
            end
            bus.tx_ready_i = 1'b1;
            @(negedge clk);
            bus.tx_ready_i = 1'b0;
            checkOutput("tx_valid after handshake", bus.tx_valid_o, 0);
            for (int i = 0; i < rxBytes.size(); i++) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                bus.rx_valid_i = 1'b1;
                bus.rx_byte_i  = rxBytes[i];
                @(negedge clk);
                bus.rx_valid_i = 1'b0;
                bus.rx_byte_i  = 8'($urandom);
                if (op == 3'd2 && (i % 2) == 1) begin
                    checkOutput("word_valid", bus.word_valid_o, 1);
                    checkOutput("word_data", bus.word_data_o, {rxBytes[i-1], rxBytes[i]});
                    checkOutput("word_count step", bus.word_count_o, i / 2 + 1);
                end
            end
        end

        cyc = 0;
        while (!bus.done_o && cyc < 4 * TIMEOUT) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("done seen", bus.done_o, 1);
        if (timed) checkOutput("timeout latency", cyc, TIMEOUT);
        checkOutput("status", bus.status_o, expStatus);
        checkOutput("word_count", bus.word_count_o, expCount);
        @(negedge clk);
        checkOutput("done single cycle", bus.done_o, 0);
        checkOutput("idle after done", {bus.busy_o, bus.cmd_ready_o}, 2'b01);
        checkOutput("status held", bus.status_o, expStatus);
        repeat (2) @(negedge clk);
        checkOutput("done pulse count", doneCount - doneBase, 1);
        checkOutput("word strobes", wordQ.size() - wordBase, expWords.size());
        for (int i = 0; i < expWords.size() && (wordBase + i) < wordQ.size(); i++) begin
            checkOutput("word stream", wordQ[wordBase + i], expWords[i]);
        end
    endtask

    initial begin
        int          doneBase;
        int unsigned kind;
        logic [2:0]  op;
        logic [7:0]  arg;
        logic [7:0]  stBytes[$];

        reset           = 1'b1;
        bus.cmd_valid_i = 1'b0;
        bus.cmd_op_i    = '0;
        bus.cmd_arg_i   = '0;
        bus.tx_ready_i  = 1'b0;
        bus.rx_byte_i   = '0;
        bus.rx_valid_i  = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset cmd_ready", bus.cmd_ready_o, 1);
        checkOutput("reset outputs", {bus.busy_o, bus.tx_valid_o, bus.done_o, bus.word_valid_o, bus.status_o}, 0);
        checkOutput("reset data", {bus.tx_byte_o, bus.word_data_o, bus.word_count_o}, 0);
        reset = 1'b0;
        @(negedge clk);

        rxBytes = {8'h06};
        applyStimulus(3'd0, 8'h00, 3);
        rxBytes = {8'hA4};
        applyStimulus(3'd4, 8'hA5, 1);
        rxBytes = {8'hA5};
        applyStimulus(3'd4, 8'hA5, 0);
        rxBytes = {};
        applyStimulus(3'd1, 8'h00, 2);
        rxBytes = {8'h15};
        applyStimulus(3'd1, 8'h00, 0);
        rxBytes = {8'h12, 8'h34, 8'h04, 8'h00, 8'hFF, 8'hFF, 8'hAB, 8'hCD};
        applyStimulus(3'd2, 8'h00, 1);
        rxBytes = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        applyStimulus(3'd2, 8'h00, 0);
        rxBytes = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
        applyStimulus(3'd2, 8'h00, 0);
        rxBytes = {};
        applyStimulus(3'd2, 8'h00, 0);
        applyStimulus(3'd6, 8'h00, 0);

        // Abort an ST transfer with reset while the low byte is pending.
        doneBase        = doneCount;
        bus.cmd_valid_i = 1'b1;
        bus.cmd_op_i    = 3'd2;
        @(negedge clk);
        bus.cmd_valid_i = 1'b0;
        bus.tx_ready_i  = 1'b1;
        @(negedge clk);
        bus.tx_ready_i  = 1'b0;
        stBytes = {8'h11, 8'h22, 8'h33};
        foreach (stBytes[i]) begin
            bus.rx_valid_i = 1'b1;
            bus.rx_byte_i  = stBytes[i];
            @(negedge clk);
            bus.rx_valid_i = 1'b0;
        end
        checkOutput("mid-ST busy", bus.busy_o, 1);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("abort busy/tx/done", {bus.busy_o, bus.tx_valid_o, bus.done_o}, 0);
        checkOutput("abort cmd_ready", bus.cmd_ready_o, 1);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("abort no done", doneCount - doneBase, 0);
        rxBytes = {};
        applyStimulus(3'd3, 8'h00, 2);

        for (int n = 0; n < 40; n++) begin
            op  = 3'($urandom_range(0, 7));
            arg = 8'($urandom);
            rxBytes = {};
            if (op == 3'd0 || op == 3'd1 || op == 3'd4) begin
                kind = $urandom_range(0, 2);
                if (kind == 1) rxBytes.push_back((op == 3'd4) ? arg : 8'h06);
                else if (kind == 2) rxBytes.push_back(8'($urandom));
            end else if (op == 3'd2) begin
                kind = $urandom_range(0, 2 * MAXW);
                for (int k = 0; k < int'(kind); k++) rxBytes.push_back(8'($urandom));
            end
            bus.rx_valid_i = 1'b1;
            bus.rx_byte_i  = 8'h06;
            @(negedge clk);
            bus.rx_valid_i = 1'b0;
            checkOutput("rx ignored in idle", {bus.busy_o, bus.done_o}, 0);
            applyStimulus(op, arg, int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
